// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock generated in the clk_in domain,
// reporting lock once the period is stable and timeout when the divided clock stops.
module div_clk_monitor #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 200
) (
    input  logic             rst,
    input  logic             clk_in,
    input  logic             en,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    // state  | meaning
    // S_IDLE | disabled or waiting for the first rising edge
    // S_MEAS | measuring, one result per rising edge
    // S_TOUT | divided clock stopped, waiting for it to resume
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEAS = 2'd1;
    localparam logic [1:0] S_TOUT = 2'd2;

    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       LOCK_VAL = 4'(LOCK_CNT);

    logic [1:0]       state_q, state_d;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       match_next;
    logic             rise;

    always_comb begin
        rise = div_in & ~div_q;

        if (rise)
            cnt_d = CNT_W'(1);
        else if (cnt_q < TO_VAL)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

        if (rise)
            hcnt_d = CNT_W'(1);
        else if (div_in && (hcnt_q != CNT_MAX))
            hcnt_d = hcnt_q + 1'b1;
        else
            hcnt_d = hcnt_q;

        // match_cnt of zero marks the first measurement since entering MEAS
        if (match_cnt_q == 4'd0)
            match_next = 4'd1;
        else if (cnt_q == period_q)
            match_next = (match_cnt_q >= LOCK_VAL) ? LOCK_VAL : match_cnt_q + 4'd1;
        else
            match_next = 4'd1;

        state_d      = state_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        match_cnt_d  = match_cnt_q;

        if (!en) begin
            state_d     = S_IDLE;
            locked_d    = 1'b0;
            timeout_d   = 1'b0;
            match_cnt_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) state_d = S_MEAS;
                end
                S_MEAS: begin
                    if (rise) begin
                        period_d     = cnt_q;
                        high_time_d  = hcnt_q;
                        meas_valid_d = 1'b1;
                        match_cnt_d  = match_next;
                        locked_d     = (match_next >= LOCK_VAL);
                    end else if (cnt_q == TO_VAL) begin
                        state_d     = S_TOUT;
                        timeout_d   = 1'b1;
                        locked_d    = 1'b0;
                        match_cnt_d = 4'd0;
                    end
                end
                S_TOUT: begin
                    if (rise) begin
                        timeout_d = 1'b0;
                        state_d   = S_MEAS;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            div_q        <= 1'b1;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            match_cnt_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_in;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
            match_cnt_q  <= match_cnt_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
Receive-side companion to the team's clock dividers. It takes a divided clock generated in the clk_in domain and measures its period and high time in clk_in cycles. It flags when the measurement is stable (locked) and when the divided clock has stopped (timeout). It sits beside any divider output as a built-in checker and a ratio reporter for status registers.

Parameters:
CNT_W, 8, width of the period/high-time counters and outputs.
LOCK_CNT, 4, number of consecutive identical period measurements required to assert locked (1..15).
TIMEOUT, 200, maximum clk_in cycles between div_in rising edges before timeout (2..2^CNT_W-1).

Ports:
rst  input  1  asynchronous, active-low reset
clk_in  input  1  clock
en  input  1  monitor enable; low forces IDLE
div_in  input  1  divided clock under test, synchronous to clk_in
period  output  CNT_W  last measured rise-to-rise interval, clk_in cycles
high_time  output  CNT_W  cycles div_in was high within the last measured period
meas_valid  output  1  one-cycle pulse when period/high_time update
locked  output  1  LOCK_CNT consecutive equal periods seen
timeout  output  1  no rising edge within TIMEOUT cycles

Behaviour:
- Reset (rst=0, async): period=0, high_time=0, meas_valid=0, locked=0, timeout=0, state=IDLE, counters=0.
- Reset value of div_q (the registered copy of div_in) is 1. div_in already high at reset release is not an edge.
- Edge detect: rise = div_in & ~div_q, evaluated combinationally on the current sample. div_q <= div_in every cycle.
- Counters:
  - cnt: loaded to 1 on rise, else increments, saturating at TIMEOUT.
  - hcnt: loaded to 1 on rise, else increments when div_in=1, saturating at 2^CNT_W-1.
- States:
  - IDLE: counters run. On rise with en=1 -> MEAS. No meas_valid is produced on this first edge.
  - MEAS:
    - On rise: registered update, visible the next cycle: period<=cnt, high_time<=hcnt, meas_valid=1 for exactly one cycle. Stay in MEAS.
    - If no rise and cnt==TIMEOUT: -> TOUT, timeout<=1, locked<=0, match count cleared.
  - TOUT: timeout stays high. On rise, timeout<=0 and -> MEAS with counters restarted. No meas_valid on this edge.
- Latency: rise sampled at cycle t -> outputs updated and meas_valid high at t+1. For a div_in pattern of 2 high / 3 low: period=5, high_time=2.
- Lock:
  - match_cnt (4 bits) is updated on each measurement.
  - First measurement after entering MEAS sets match_cnt=1.
  - New period equal to the previous period: match_cnt+1, saturating at LOCK_CNT.
  - Different period: match_cnt=1.
  - locked = (match_cnt >= LOCK_CNT), registered. It updates in the same cycle as meas_valid, so locked drops together with the first mismatching meas_valid.
- Simultaneous events: rise in the cycle where cnt==TIMEOUT counts as a rise. Result: valid measurement with period=TIMEOUT, no timeout.
- en=0: synchronous -> IDLE; locked=0, timeout=0, match_cnt=0, meas_valid=0. period/high_time hold their last values. After re-enable, two rises are needed for the next meas_valid.
- Reset mid-operation: everything returns to reset values immediately. No pending meas_valid survives.
- Widths: high_time is always <= period for legal inputs. Outputs are unsigned.

Test Plan:
1. Reset, then en=1 with div_in repeating 1,1,0,0,0 -> meas_valid pulses every 5 cycles starting one cycle after the 2nd rise; period=5, high_time=2. locked rises with the 4th meas_valid and stays high.
2. After lock, switch div_in to 1,1,1,0,0,0,0 -> next meas_valid carries period=7, high_time=3, and locked=0 in that same cycle. locked re-asserts on the 4th consecutive period=7 measurement.
3. After lock, hold div_in=0 (TIMEOUT=200) -> timeout=1 and locked=0 at last rise +201 cycles. Resume the 5-cycle pattern: 1st rise clears timeout with no meas_valid; 2nd rise gives meas_valid, period=5.
4. Rise arrives exactly 200 cycles after the previous rise -> meas_valid with period=200 (0xC8); timeout stays 0.
5. Assert rst mid-period with div_in=1 -> all outputs 0 immediately. Release with div_in still high -> no meas_valid until two genuine rises occur.
6. Drop en for 10 cycles while locked -> locked=0 and period holds 5. Re-raise en -> first meas_valid comes only after two rises; relock after 4 matching measurements.
